pwm_cfg_arbiter: RTL and testbench

PWM_CFG_ARBITER -- requirements
Module: pwm_cfg_arbiter

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_rr_arb2.sv | 28 ++
 rtl/pwm_cfg_arbiter.sv | 122 ++++++++++++
 tb/tb_pwm_cfg_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM configuration arbiter.
// The FSM state encoding, default data width and GAP counter width live here.
package pwm_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int GAP_CW     = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR_HI,
    GAP_HI,
    WR_LO,
    GAP_LO,
    ACK
  } state_t;

endpackage

// File: rtl/pwm_rr_arb2.sv
// Two-way round-robin grant with its priority pointer.
// The pointer names the requester that wins a tie and flips to the loser whenever a grant is taken.
module pwm_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic any,
  output logic id,
  output logic rr
);

  always_comb begin
    any = req0 | req1;
    // A lone request wins outright; only a tie consults the pointer.
    id  = (req0 && req1) ? rr : req1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr <= 1'b0;
    end else if (take) begin
      rr <= ~id;
    end
  end

endmodule

// File: rtl/pwm_cfg_arbiter.sv
// Arbitrates two requesters onto one PWM generator config port: a high-time write, GAP idle
// cycles, a low-time write, GAP idle cycles, then an ack. Optional macro: PWM_CFG_ZERO_GUARD_EN.
module pwm_cfg_arbiter
  import pwm_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int GAP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] hi0,
  input  logic [DW-1:0] lo0,
  input  logic [DW-1:0] hi1,
  input  logic [DW-1:0] lo1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] data_out,
  output logic          high_write,
  output logic          low_write,
  output logic          busy,
  output logic          grant_id
);

  localparam logic [GAP_CW-1:0] GAP_LOAD = GAP_CW'(GAP - 1);

  state_t            state;
  logic              gid;
  logic [DW-1:0]     lo_lat;
  logic [GAP_CW-1:0] gap_cnt;

  logic arb_any;
  logic arb_id;
  logic arb_rr;
  logic take;

  function automatic logic [DW-1:0] drive_val(input logic [DW-1:0] v);
`ifdef PWM_CFG_ZERO_GUARD_EN
    return (v == '0) ? DW'(1) : v;
`else
    return v;
`endif
  endfunction

  assign take = (state == IDLE) && arb_any;

  pwm_rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .take (take),
    .any  (arb_any),
    .id   (arb_id),
    .rr   (arb_rr)
  );

  // The grant cycle is the IDLE cycle that sees a request, so busy/grant_id lead the registers by one cycle.
  assign busy     = ~rst & ((state != IDLE) | take);
  assign grant_id = ~rst & (take ? arb_id : gid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gid        <= 1'b0;
      lo_lat     <= '0;
      gap_cnt    <= '0;
      data_out   <= '0;
      high_write <= 1'b0;
      low_write  <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
    end else begin
      high_write <= 1'b0;
      low_write  <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            // data_out itself holds the latched high time through WR_HI and GAP_HI.
            gid        <= arb_id;
            lo_lat     <= arb_id ? lo1 : lo0;
            data_out   <= drive_val(arb_id ? hi1 : hi0);
            high_write <= 1'b1;
            state      <= WR_HI;
          end
        end
        WR_HI: begin
          gap_cnt <= GAP_LOAD;
          state   <= GAP_HI;
        end
        GAP_HI: begin
          if (gap_cnt == '0) begin
            data_out  <= drive_val(lo_lat);
            low_write <= 1'b1;
            state     <= WR_LO;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        WR_LO: begin
          gap_cnt <= GAP_LOAD;
          state   <= GAP_LO;
        end
        GAP_LO: begin
          if (gap_cnt == '0) begin
            ack0  <= ~gid;
            ack1  <= gid;
            state <= ACK;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Directed self-checking bench for pwm_cfg_arbiter (DW=16, GAP=1).
// Inputs change 1ns after posedge; outputs are sampled on the negedge.
module tb_pwm_cfg_arbiter;

  localparam int DW  = 16;
  localparam int GAP = 1;
`ifdef PWM_CFG_ZERO_GUARD_EN
  localparam logic [DW-1:0] ZEXP = 16'd1;
`else
  localparam logic [DW-1:0] ZEXP = 16'd0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [DW-1:0] hi0 = '0, lo0 = '0, hi1 = '0, lo1 = '0;
  logic          ack0, ack1, high_write, low_write, busy, grant_id;
  logic [DW-1:0] data_out;

  int checks = 0;
  int errors = 0;

  pwm_cfg_arbiter #(.DW(DW), .GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .hi0        (hi0),
    .lo0        (lo0),
    .hi1        (hi1),
    .lo1        (lo1),
    .ack0       (ack0),
    .ack1       (ack1),
    .data_out   (data_out),
    .high_write (high_write),
    .low_write  (low_write),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Protocol monitor: exclusive one-cycle strobes, one ack per grant.
  logic hw_prev = 1'b0, lw_prev = 1'b0, busy_prev = 1'b0, ack_prev = 1'b0;
  logic outstanding = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      hw_prev = 1'b0; lw_prev = 1'b0; busy_prev = 1'b0; ack_prev = 1'b0;
      outstanding = 1'b0;
    end else begin
      checks++;
      if ((high_write && low_write) || (high_write && hw_prev) || (low_write && lw_prev)
          || (ack0 && ack1)) begin
        errors++;
        $display("FAIL protocol_strobe: hw=%b lw=%b hw_prev=%b lw_prev=%b ack0=%b ack1=%b required exclusive single-cycle pulses",
                 high_write, low_write, hw_prev, lw_prev, ack0, ack1);
      end
      if (busy && (!busy_prev || ack_prev)) begin
        if (outstanding) begin
          errors++;
          $display("FAIL protocol_grant: new grant while previous unacked (outstanding=1 required 0)");
        end
        outstanding = 1'b1;
      end
      if (ack0 || ack1) begin
        if (!outstanding) begin
          errors++;
          $display("FAIL protocol_ack: ack with no outstanding grant (outstanding=0 required 1)");
        end
        outstanding = 1'b0;
      end
      hw_prev = high_write; lw_prev = low_write; busy_prev = busy; ack_prev = ack0 | ack1;
    end
  end

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1;
    @(negedge clk);
    checks++;
    if ({data_out, high_write, low_write, ack0, ack1, busy, grant_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h hw=%b lw=%b ack0=%b ack1=%b busy=%b gid=%b required all 0",
               data_out, high_write, low_write, ack0, ack1, busy, grant_id);
    end
    step(); step();
    rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: busy=%b required 0", busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [DW+4:0] got, expv;
    step(); req0 = 1'b1; hi0 = 16'd5; lo0 = 16'd3;
    @(negedge clk);
    checks++;
    if ({busy, grant_id, high_write} !== 3'b100) begin
      errors++;
      $display("FAIL single_grant: busy=%b gid=%b hw=%b required 1 0 0", busy, grant_id, high_write);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 6) req0 = 1'b0;
      @(negedge clk);
      got  = {high_write, low_write, ack0, ack1, busy, data_out};
      expv = {k == 1, k == 3, k == 5, 1'b0, k <= 5, (k <= 2) ? 16'd5 : 16'd3};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL single_cycle%0d: {hw,lw,ack0,ack1,busy,data}=%h required %h", k, got, expv);
      end
    end
    $display("test_single done");
  endtask

  task automatic test_conflict();
    logic [DW-1:0] exp_hi, exp_lo;
    logic          exp_id;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    step();
    req0 = 1'b1; req1 = 1'b1;
    hi0 = 16'h0011; lo0 = 16'h0022; hi1 = 16'h0033; lo1 = 16'h0044;
    for (int n = 0; n < 4; n++) begin
      exp_id = n[0];
      exp_hi = exp_id ? 16'h0033 : 16'h0011;
      exp_lo = exp_id ? 16'h0044 : 16'h0022;
      @(negedge clk);
      checks++;
      if ({busy, grant_id} !== {1'b1, exp_id}) begin
        errors++;
        $display("FAIL conflict_grant%0d: busy=%b gid=%b required 1 %b", n, busy, grant_id, exp_id);
      end
      for (int k = 1; k <= 5; k++) begin
        step();
        @(negedge clk);
        if (k == 1) begin
          checks++;
          if ({high_write, data_out} !== {1'b1, exp_hi}) begin
            errors++;
            $display("FAIL conflict_hi%0d: hw=%b data=%h required 1 %h", n, high_write, data_out, exp_hi);
          end
        end else if (k == 3) begin
          checks++;
          if ({low_write, data_out} !== {1'b1, exp_lo}) begin
            errors++;
            $display("FAIL conflict_lo%0d: lw=%b data=%h required 1 %h", n, low_write, data_out, exp_lo);
          end
        end else if (k == 5) begin
          checks++;
          if ({ack0, ack1} !== {~exp_id, exp_id}) begin
            errors++;
            $display("FAIL conflict_ack%0d: ack0=%b ack1=%b required %b %b", n, ack0, ack1, ~exp_id, exp_id);
          end
        end
      end
      step();
      if (n == 3) begin req0 = 1'b0; req1 = 1'b0; end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL conflict_idle: busy=%b required 0", busy);
    end
    $display("test_conflict done");
  endtask

  task automatic test_hold_change();
    step(); req0 = 1'b1; hi0 = 16'd5; lo0 = 16'd3;
    @(negedge clk);
    step(); hi0 = 16'd9; lo0 = 16'd7;
    @(negedge clk);
    checks++;
    if ({high_write, data_out} !== {1'b1, 16'd5}) begin
      errors++;
      $display("FAIL hold_hi: hw=%b data=%0d required 1 5", high_write, data_out);
    end
    step(); req0 = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if ({low_write, data_out} !== {1'b1, 16'd3}) begin
      errors++;
      $display("FAIL hold_lo: lw=%b data=%0d required 1 3", low_write, data_out);
    end
    step(); step();
    @(negedge clk);
    checks++;
    if ({ack0, busy} !== 2'b11) begin
      errors++;
      $display("FAIL hold_ack_after_drop: ack0=%b busy=%b required 1 1", ack0, busy);
    end
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: busy=%b required 0", busy);
    end
    $display("test_hold_change done");
  endtask

  task automatic test_reset_mid();
    step(); req0 = 1'b1; hi0 = 16'h000A; lo0 = 16'h000B;
    step(); step();
    rst = 1'b1; req0 = 1'b0;
    #1;
    checks++;
    if ({data_out, high_write, low_write, ack0, ack1, busy, grant_id} !== '0) begin
      errors++;
      $display("FAIL resetmid_outputs: data=%h hw=%b lw=%b ack0=%b ack1=%b busy=%b gid=%b required all 0",
               data_out, high_write, low_write, ack0, ack1, busy, grant_id);
    end
    step(); step();
    rst = 1'b0; req0 = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, grant_id} !== 2'b10) begin
      errors++;
      $display("FAIL resetmid_regrant: busy=%b gid=%b required 1 0", busy, grant_id);
    end
    step();
    @(negedge clk);
    checks++;
    if ({high_write, data_out} !== {1'b1, 16'h000A}) begin
      errors++;
      $display("FAIL resetmid_hi: hw=%b data=%h required 1 000a", high_write, data_out);
    end
    step(); step(); step(); step();
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b1) begin
      errors++;
      $display("FAIL resetmid_ack: ack0=%b required 1", ack0);
    end
    step(); req0 = 1'b0;
    $display("test_reset_mid done");
  endtask

  task automatic test_zero();
    step(); req1 = 1'b1; hi1 = '0; lo1 = '0;
    @(negedge clk);
    checks++;
    if ({busy, grant_id} !== 2'b11) begin
      errors++;
      $display("FAIL zero_grant: busy=%b gid=%b required 1 1", busy, grant_id);
    end
    step();
    @(negedge clk);
    checks++;
    if ({high_write, data_out} !== {1'b1, ZEXP}) begin
      errors++;
      $display("FAIL zero_hi: hw=%b data=%0d required 1 %0d", high_write, data_out, ZEXP);
    end
    step(); step();
    @(negedge clk);
    checks++;
    if ({low_write, data_out} !== {1'b1, ZEXP}) begin
      errors++;
      $display("FAIL zero_lo: lw=%b data=%0d required 1 %0d", low_write, data_out, ZEXP);
    end
    step(); step();
    @(negedge clk);
    checks++;
    if ({ack0, ack1} !== 2'b01) begin
      errors++;
      $display("FAIL zero_ack: ack0=%b ack1=%b required 0 1", ack0, ack1);
    end
    step(); req1 = 1'b0;
    $display("test_zero done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_conflict();
    test_hold_change();
    test_reset_mid();
    test_zero();
    step(); step();
    @(negedge clk);
    checks++;
    if (outstanding !== 1'b0) begin
      errors++;
      $display("FAIL final_unacked: outstanding=%b required 0", outstanding);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
